// File: rtl/retire_unit.sv
// Dual-slot in-order retirement stage: pops up to two completed ROB head entries
// per cycle, sequences store commits with the LSQ, and issues ARF/free-list updates.
module retire_unit #(
  parameter int PREG_W = 6,
  parameter int AREG_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          head_valid,
  input  logic [1:0]          head_complete,
  input  logic [1:0]          head_is_store,
  input  logic [1:0]          head_halt,
  input  logic [1:0]          head_reg_write,
  input  logic [2*AREG_W-1:0] head_dr_arch,
  input  logic [2*PREG_W-1:0] head_dr_p,
  input  logic [2*PREG_W-1:0] head_old_dr_p,
  input  logic [63:0]         head_pc,
  output logic [1:0]          retire_cnt,
  output logic                store_ret_valid,
  output logic [31:0]         store_ret_pc,
  input  logic                store_ret_ready,
  output logic [1:0]          arf_we,
  output logic [2*AREG_W-1:0] arf_waddr,
  output logic [2*PREG_W-1:0] arf_wtag,
  output logic [1:0]          free_en,
  output logic [2*PREG_W-1:0] free_tag,
  output logic                halted,
  output logic [31:0]         retired_count
);

  typedef enum logic [1:0] {RUN, STORE_WAIT, HALT} state_t;

  state_t      state, state_next;
  logic [1:0]  eligible;
  logic [1:0]  retire;
  logic [1:0]  commit;
  logic [31:0] store_pc;

  // Only slot 0 can ever be offered to the LSQ, so slot 1's PC is never consumed.
  logic unused_pc_hi;
  assign unused_pc_hi = ^head_pc[63:32];

  assign eligible = head_valid & head_complete;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next      = state;
    retire          = 2'b00;
    store_ret_valid = 1'b0;
    store_ret_pc    = '0;

    case (state)
      RUN: begin
        if (eligible[0]) begin
          if (head_is_store[0]) begin
            store_ret_valid = 1'b1;
            store_ret_pc    = head_pc[31:0];
            if (store_ret_ready) retire[0] = 1'b1;
            else                 state_next = STORE_WAIT;
          end else begin
            retire[0] = 1'b1;
            // Slot 1 pairs only behind a non-halt, and a store must reach slot 0 first.
            if (!head_halt[0] && eligible[1] && !head_is_store[1]) retire[1] = 1'b1;
          end
        end
      end
      STORE_WAIT: begin
        store_ret_valid = 1'b1;
        store_ret_pc    = store_pc;
        if (store_ret_ready) begin
          retire[0]  = 1'b1;
          state_next = RUN;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = RUN;
    endcase

    if ((retire & head_halt) != 2'b00) state_next = HALT;

    if (rst) begin
      retire          = 2'b00;
      store_ret_valid = 1'b0;
      store_ret_pc    = '0;
      state_next      = RUN;
    end
  end

  assign retire_cnt = 2'(retire[0]) + 2'(retire[1]);
  assign halted     = (state == HALT);

  // x0 is hardwired, so retiring into it neither writes the ARF nor frees a tag.
  always_comb begin
    commit = 2'b00;
    for (int k = 0; k < 2; k++) begin
      commit[k] = retire[k] & head_reg_write[k] & (head_dr_arch[k*AREG_W +: AREG_W] != '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      arf_we        <= 2'b00;
      free_en       <= 2'b00;
      retired_count <= '0;
    end else begin
      state         <= state_next;
      arf_we        <= commit;
      free_en       <= commit;
      retired_count <= retired_count + 32'(retire_cnt);
    end
  end

  // NOTE: payload registers carry no reset; they are only meaningful under their enables.
  always_ff @(posedge clk) begin
    if (state == RUN) store_pc <= head_pc[31:0];
    arf_waddr <= head_dr_arch;
    arf_wtag  <= head_dr_p;
    free_tag  <= head_old_dr_p;
  end

endmodule

// File: tb/tb_retire_unit.sv
// Directed self-checking bench for retire_unit: dual retire, store handshakes,
// x0 suppression, same-register pairs, halt, and reset out of STORE_WAIT.
module tb_retire_unit;

  localparam int PREG_W = 6;
  localparam int AREG_W = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [1:0]          head_valid, head_complete, head_is_store, head_halt, head_reg_write;
  logic [2*AREG_W-1:0] head_dr_arch;
  logic [2*PREG_W-1:0] head_dr_p, head_old_dr_p;
  logic [63:0]         head_pc;
  logic [1:0]          retire_cnt;
  logic                store_ret_valid;
  logic [31:0]         store_ret_pc;
  logic                store_ret_ready;
  logic [1:0]          arf_we, free_en;
  logic [2*AREG_W-1:0] arf_waddr;
  logic [2*PREG_W-1:0] arf_wtag, free_tag;
  logic                halted;
  logic [31:0]         retired_count;

  int vectors     = 0;
  int miscompares = 0;

  retire_unit #(.PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk(clk), .rst(rst),
    .head_valid(head_valid), .head_complete(head_complete),
    .head_is_store(head_is_store), .head_halt(head_halt),
    .head_reg_write(head_reg_write), .head_dr_arch(head_dr_arch),
    .head_dr_p(head_dr_p), .head_old_dr_p(head_old_dr_p), .head_pc(head_pc),
    .retire_cnt(retire_cnt), .store_ret_valid(store_ret_valid),
    .store_ret_pc(store_ret_pc), .store_ret_ready(store_ret_ready),
    .arf_we(arf_we), .arf_waddr(arf_waddr), .arf_wtag(arf_wtag),
    .free_en(free_en), .free_tag(free_tag),
    .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_heads();
    head_valid     = '0;
    head_complete  = '0;
    head_is_store  = '0;
    head_halt      = '0;
    head_reg_write = '0;
    head_dr_arch   = '0;
    head_dr_p      = '0;
    head_old_dr_p  = '0;
    head_pc        = '0;
  endtask

  task automatic set_slot(input int k, input logic v, input logic c, input logic st, input logic h,
                          input logic rw, input logic [AREG_W-1:0] arch,
                          input logic [PREG_W-1:0] tag, input logic [PREG_W-1:0] old_tag,
                          input logic [31:0] pc);
    head_valid[k]                  = v;
    head_complete[k]               = c;
    head_is_store[k]               = st;
    head_halt[k]                   = h;
    head_reg_write[k]              = rw;
    head_dr_arch[k*AREG_W +: AREG_W] = arch;
    head_dr_p[k*PREG_W +: PREG_W]    = tag;
    head_old_dr_p[k*PREG_W +: PREG_W] = old_tag;
    head_pc[k*32 +: 32]            = pc;
  endtask

  initial begin
    rst = 1'b1;
    store_ret_ready = 1'b0;
    clear_heads();
    tick();
    tick();

    // Outputs held low while reset is asserted, even with an eligible head.
    set_slot(0, 1, 1, 0, 0, 1, 5'd4, 6'd20, 6'd4, 32'h10);
    #1;
    check("rst_retire_cnt", 64'(retire_cnt), 64'd0);
    check("rst_store_valid", 64'(store_ret_valid), 64'd0);
    tick();
    rst = 1'b0;
    clear_heads();
    #1;
    check("reset_arf_we", 64'(arf_we), 64'd0);
    check("reset_free_en", 64'(free_en), 64'd0);
    check("reset_halted", 64'(halted), 64'd0);
    check("reset_count", 64'(retired_count), 64'd0);

    // Two eligible ALU ops retire together.
    set_slot(0, 1, 1, 0, 0, 1, 5'd5, 6'd33, 6'd5, 32'h100);
    set_slot(1, 1, 1, 0, 0, 1, 5'd6, 6'd34, 6'd6, 32'h104);
    #1;
    check("dual_retire_cnt", 64'(retire_cnt), 64'd2);
    tick();
    clear_heads();
    #1;
    check("dual_arf_we", 64'(arf_we), 64'b11);
    check("dual_arf_waddr", 64'(arf_waddr), 64'({5'd6, 5'd5}));
    check("dual_arf_wtag", 64'(arf_wtag), 64'({6'd34, 6'd33}));
    check("dual_free_en", 64'(free_en), 64'b11);
    check("dual_free_tag", 64'(free_tag), 64'({6'd6, 6'd5}));
    check("dual_count", 64'(retired_count), 64'd2);

    // Incomplete slot 0 blocks a complete slot 1.
    set_slot(0, 1, 0, 0, 0, 1, 5'd7, 6'd35, 6'd7, 32'h108);
    set_slot(1, 1, 1, 0, 0, 1, 5'd8, 6'd36, 6'd8, 32'h10c);
    #1;
    check("inorder_retire_cnt", 64'(retire_cnt), 64'd0);
    tick();
    clear_heads();
    #1;
    check("inorder_arf_we", 64'(arf_we), 64'd0);
    check("inorder_free_en", 64'(free_en), 64'd0);
    check("inorder_count", 64'(retired_count), 64'd2);

    // Write to x0 retires but commits nothing.
    set_slot(0, 1, 1, 0, 0, 1, 5'd0, 6'd40, 6'd9, 32'h110);
    #1;
    check("x0_retire_cnt", 64'(retire_cnt), 64'd1);
    tick();
    clear_heads();
    #1;
    check("x0_arf_we", 64'(arf_we), 64'd0);
    check("x0_free_en", 64'(free_en), 64'd0);
    check("x0_count", 64'(retired_count), 64'd3);

    // Store at slot 0, LSQ not ready for three cycles.
    set_slot(0, 1, 1, 1, 0, 0, 5'd0, 6'd0, 6'd0, 32'h40);
    store_ret_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("st_wait_valid", 64'(store_ret_valid), 64'd1);
      check("st_wait_pc", 64'(store_ret_pc), 64'h40);
      check("st_wait_cnt", 64'(retire_cnt), 64'd0);
      tick();
    end
    store_ret_ready = 1'b1;
    #1;
    check("st_ready_valid", 64'(store_ret_valid), 64'd1);
    check("st_ready_pc", 64'(store_ret_pc), 64'h40);
    check("st_ready_cnt", 64'(retire_cnt), 64'd1);
    tick();
    store_ret_ready = 1'b0;
    clear_heads();
    #1;
    check("st_done_valid", 64'(store_ret_valid), 64'd0);
    check("st_done_count", 64'(retired_count), 64'd4);

    // ALU at slot 0, store at slot 1: store waits to reach slot 0.
    store_ret_ready = 1'b1;
    set_slot(0, 1, 1, 0, 0, 1, 5'd3, 6'd20, 6'd3, 32'h7c);
    set_slot(1, 1, 1, 1, 0, 0, 5'd0, 6'd0, 6'd0, 32'h80);
    #1;
    check("mix_retire_cnt", 64'(retire_cnt), 64'd1);
    check("mix_store_valid", 64'(store_ret_valid), 64'd0);
    tick();
    clear_heads();
    set_slot(0, 1, 1, 1, 0, 0, 5'd0, 6'd0, 6'd0, 32'h80);
    #1;
    check("mix_st_valid", 64'(store_ret_valid), 64'd1);
    check("mix_st_pc", 64'(store_ret_pc), 64'h80);
    check("mix_st_cnt", 64'(retire_cnt), 64'd1);
    check("mix_arf_we", 64'(arf_we), 64'b01);
    check("mix_free_tag0", 64'(free_tag[PREG_W-1:0]), 64'd3);
    tick();
    store_ret_ready = 1'b0;
    clear_heads();
    #1;
    check("mix_count", 64'(retired_count), 64'd6);

    // Both slots target x7: two writes, both old tags freed.
    set_slot(0, 1, 1, 0, 0, 1, 5'd7, 6'd50, 6'd10, 32'h200);
    set_slot(1, 1, 1, 0, 0, 1, 5'd7, 6'd51, 6'd11, 32'h204);
    #1;
    check("same_retire_cnt", 64'(retire_cnt), 64'd2);
    tick();
    clear_heads();
    #1;
    check("same_arf_we", 64'(arf_we), 64'b11);
    check("same_arf_waddr", 64'(arf_waddr), 64'({5'd7, 5'd7}));
    check("same_arf_wtag", 64'(arf_wtag), 64'({6'd51, 6'd50}));
    check("same_free_tag", 64'(free_tag), 64'({6'd11, 6'd10}));
    check("same_count", 64'(retired_count), 64'd8);

    // Halt at slot 0; slot 1 never pairs with it, and later heads are ignored.
    set_slot(0, 1, 1, 0, 1, 0, 5'd0, 6'd0, 6'd0, 32'h300);
    set_slot(1, 1, 1, 0, 0, 1, 5'd9, 6'd52, 6'd12, 32'h304);
    #1;
    check("halt_retire_cnt", 64'(retire_cnt), 64'd1);
    tick();
    clear_heads();
    set_slot(0, 1, 1, 1, 0, 0, 5'd0, 6'd0, 6'd0, 32'h308);
    set_slot(1, 1, 1, 0, 0, 1, 5'd9, 6'd52, 6'd12, 32'h30c);
    store_ret_ready = 1'b1;
    #1;
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_count", 64'(retired_count), 64'd9);
    check("halt_ignore_cnt", 64'(retire_cnt), 64'd0);
    check("halt_ignore_store", 64'(store_ret_valid), 64'd0);
    tick();
    store_ret_ready = 1'b0;
    #1;
    check("halt_hold_count", 64'(retired_count), 64'd9);
    check("halt_hold_arf_we", 64'(arf_we), 64'd0);

    // Reset leaves HALT, then reset again while parked in STORE_WAIT.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_heads();
    #1;
    check("rerst_halted", 64'(halted), 64'd0);
    check("rerst_count", 64'(retired_count), 64'd0);
    set_slot(0, 1, 1, 1, 0, 0, 5'd0, 6'd0, 6'd0, 32'h500);
    tick();
    #1;
    check("sw_pre_valid", 64'(store_ret_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("sw_rst_comb_valid", 64'(store_ret_valid), 64'd0);
    tick();
    rst = 1'b0;
    clear_heads();
    #1;
    check("sw_rst_valid", 64'(store_ret_valid), 64'd0);
    check("sw_rst_count", 64'(retired_count), 64'd0);
    set_slot(0, 1, 1, 0, 0, 1, 5'd2, 6'd30, 6'd2, 32'h504);
    #1;
    check("sw_rst_run_cnt", 64'(retire_cnt), 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "bench timed out");
  end

endmodule
